// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int PARITY_NONE  = 0;
  localparam int PARITY_EVEN  = 1;
  localparam int PARITY_ODD   = 2;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;
`endif

  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator for the UART receiver.
// restart realigns the tick phase to a detected start edge.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, 1 stop bit, valid/ready output buffer.
// Define UART_RX_PARITY_EN to compile in the PARITY state (PARITY_MODE).
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_MODE  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY_MODE != PARITY_NONE);
  localparam bit PAR_ODD = (PARITY_MODE == PARITY_ODD);
  logic r_pflag, w_pflag_nxt;
  logic w_perr, r_perr;
`endif

  logic       r_sync1, r_sync2, r_sync3;
  state_t     r_state, w_state_nxt;
  logic [3:0] r_tick_cnt, w_tick_nxt;
  logic [2:0] r_bit_idx, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       w_tick, w_restart, w_done, w_ferr;
  logic       w_mid, w_end;
  logic [7:0] r_data;
  logic       r_valid, r_ferr, r_ovr;

  // r_sync3 only feeds falling-edge detection in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  uart_baud_gen #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(w_restart),
    .tick   (w_tick)
  );

  assign w_mid = w_tick && (r_tick_cnt == MID);
  assign w_end = w_tick && (r_tick_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_pflag    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_pflag    <= w_pflag_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_restart   = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pflag_nxt = r_pflag;
    w_perr      = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (!r_sync2 && r_sync3) begin
          w_state_nxt = START;
          w_tick_nxt  = '0;
          w_restart   = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_pflag_nxt = 1'b0;
`endif
        end
      end
      START: begin
        if (w_mid) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_sync2 ? IDLE : DATA;
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
        end
      end
      DATA: begin
        if (w_end) begin
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_tick_nxt  = '0;
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PAR_ON ? PARITY : STOP;
`else
            w_state_nxt = STOP;
`endif
          end
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_end) begin
          w_tick_nxt  = '0;
          w_state_nxt = STOP;
          if ((^{r_shift, r_sync2}) != PAR_ODD) begin
            w_perr      = 1'b1;
            w_pflag_nxt = 1'b1;
          end
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
        end
      end
`endif
      STOP: begin
        if (w_end) begin
          w_tick_nxt = '0;
          if (r_sync2) begin
            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            w_done = !r_pflag;
`else
            w_done = 1'b1;
`endif
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else if (w_tick) begin
          w_tick_nxt = r_tick_cnt + 4'd1;
        end
      end
      WAIT_IDLE: begin
        if (r_sync2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A completing byte is accepted if the buffer is free or drains this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_perr <= 1'b0;
    else        r_perr <= w_perr;
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
